// File: rtl/param_register_file.sv
// ============================================================================
// Module   : param_register_file
// Brief    : Parameterised multi-port register file with debug port, carry flag,
//            post-reset clear sequence and write-conflict detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef STATE_HALTED
`define STATE_HALTED 3'b111
`endif

module param_register_file #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 64,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic [5:0]       rega_rregnum,
  input  logic [5:0]       rega_wregnum,
  output logic [WIDTH-1:0] rega_rdata,
  input  logic [WIDTH-1:0] rega_wdata,
  input  logic             rega_we,
  input  logic [5:0]       regb_rregnum,
  input  logic [5:0]       regb_wregnum,
  output logic [WIDTH-1:0] regb_rdata,
  input  logic [WIDTH-1:0] regb_wdata,
  input  logic             regb_we,
  input  logic [5:0]       regd_rregnum,
  input  logic [5:0]       regd_wregnum,
  output logic [WIDTH-1:0] regd_rdata,
  input  logic [WIDTH-1:0] regd_wdata,
  input  logic             regd_we,
  input  logic [5:0]       dbg_reg_rregnum,
  input  logic [5:0]       dbg_reg_wregnum,
  output logic [WIDTH-1:0] dbg_reg_rdata,
  input  logic [WIDTH-1:0] dbg_reg_wdata,
  input  logic             dbg_reg_we,
  output logic             carry_rdata,
  input  logic             carry_wdata,
  input  logic             carry_we,
  output logic             init_busy,
  output logic             wr_conflict,
  input  logic             wr_conflict_clr
);

  localparam int         C_NPORTS = 4;
  localparam logic [5:0] C_LAST   = 6'(NREGS - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           fsm_q, fsm_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             conflict_q, conflict_d;
  logic [WIDTH-1:0] mem_q [NREGS];

  logic             w_run;
  logic             w_halted;
  logic             w_wen  [NREGS];
  logic [WIDTH-1:0] w_wdat [NREGS];
  logic             w_conflict;
  logic [5:0]       w_ridx [C_NPORTS];
  logic [WIDTH-1:0] w_rdat [C_NPORTS];
  int               w_hits;

  assign w_run    = (fsm_q == S_RUN);
  assign w_halted = (state == `STATE_HALTED);

  // Index matching against the loop variable performs the range check:
  // indices >= NREGS never match any implemented register.
  always_comb begin : write_decode
    w_conflict = 1'b0;
    w_hits     = 0;
    for (int i = 0; i < NREGS; i++) begin
      w_wen[i]  = 1'b0;
      w_wdat[i] = '0;
      w_hits    = 0;
      if (w_run && !w_halted) begin
        if (rega_we && rega_wregnum == 6'(i)) begin
          w_wen[i]  = 1'b1;
          w_wdat[i] = rega_wdata;
          w_hits    = w_hits + 1;
        end
        if (regb_we && regb_wregnum == 6'(i)) begin
          w_wen[i]  = 1'b1;
          w_wdat[i] = regb_wdata;
          w_hits    = w_hits + 1;
        end
        if (regd_we && regd_wregnum == 6'(i)) begin
          w_wen[i]  = 1'b1;
          w_wdat[i] = regd_wdata;
          w_hits    = w_hits + 1;
        end
      end
      if (w_run && w_halted && dbg_reg_we && dbg_reg_wregnum == 6'(i)) begin
        w_wen[i]  = 1'b1;
        w_wdat[i] = dbg_reg_wdata;
      end
      if (w_hits > 1) begin
        w_conflict = 1'b1;
      end
    end
  end

  assign w_ridx[0] = rega_rregnum;
  assign w_ridx[1] = regb_rregnum;
  assign w_ridx[2] = regd_rregnum;
  assign w_ridx[3] = dbg_reg_rregnum;

  always_comb begin : read_mux
    for (int p = 0; p < C_NPORTS; p++) begin
      w_rdat[p] = '0;
      for (int i = 0; i < NREGS; i++) begin
        if (w_run && w_ridx[p] == 6'(i)) begin
          w_rdat[p] = ((BYPASS != 0) && w_wen[i]) ? w_wdat[i] : mem_q[i];
        end
      end
    end
  end

  assign rega_rdata    = w_rdat[0];
  assign regb_rdata    = w_rdat[1];
  assign regd_rdata    = w_rdat[2];
  assign dbg_reg_rdata = w_rdat[3];
  assign carry_rdata   = w_run ? (((BYPASS != 0) && carry_we) ? carry_wdata : carry_q) : 1'b0;
  assign init_busy     = (fsm_q == S_INIT);
  assign wr_conflict   = conflict_q;

  always_comb begin : next_state
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    conflict_d = conflict_q;
    case (fsm_q)
      S_INIT: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == C_LAST) begin
          fsm_d = S_RUN;
          cnt_d = '0;
        end
      end
      S_RUN: begin
        if (carry_we) begin
          carry_d = carry_wdata;
        end
      end
      default: begin
        fsm_d = S_INIT;
        cnt_d = '0;
      end
    endcase
    if (w_conflict) begin
      conflict_d = 1'b1;
    end else if (wr_conflict_clr) begin
      conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= S_INIT;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage has no reset; contents are cleared one entry per cycle during INIT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (fsm_q == S_INIT && cnt_q == 6'(i)) begin
        mem_q[i] <= '0;
      end else if (w_wen[i]) begin
        mem_q[i] <= w_wdat[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register and data port.
REQ-002 Parameter NREGS, default 64, number of implemented registers, legal range 2..64.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 Port state  input  3  processor state; `STATE_HALTED selects debug-only writes.
REQ-007 Ports rega_/regb_/regd_ rregnum, wregnum  input  6 each  read and write register indices.
REQ-008 Ports rega_/regb_/regd_ rdata  output  WIDTH  read data; wdata  input  WIDTH; we  input  1.
REQ-009 Ports dbg_reg_rregnum, dbg_reg_wregnum  input  6; dbg_reg_rdata  output  WIDTH; dbg_reg_wdata  input  WIDTH; dbg_reg_we  input  1.
REQ-010 Ports carry_rdata  output  1; carry_wdata  input  1; carry_we  input  1: single carry flag.
REQ-011 Port init_busy  output  1  high while post-reset clear sequence runs.
REQ-012 Port wr_conflict  output  1  sticky flag, same-index multi-port write seen; wr_conflict_clr  input  1 clears it.

Function
REQ-013 FSM states INIT and RUN; INIT clears register[cnt] to 0 each cycle, cnt 0..NREGS-1, then RUN on the cycle after cnt=NREGS-1 (exactly NREGS cycles of init_busy=1).
REQ-014 In INIT all write enables (including carry and debug) are ignored and all rdata outputs read 0.
REQ-015 In RUN, read ports are combinational: rdata = register[rregnum]; index >= NREGS reads 0.
REQ-016 Writes with wregnum >= NREGS are discarded; no other register changes.
REQ-017 state != `STATE_HALTED: rega/regb/regd/carry writes honoured, debug write ignored.
REQ-018 state == `STATE_HALTED: only dbg_reg write and carry write honoured; rega/regb/regd writes ignored.
REQ-019 Same-cycle same-index writes: priority regd > regb > rega; losing data discarded.
REQ-020 wr_conflict sets on the edge following any cycle where two or more honoured writes target one index; stays set until wr_conflict_clr sampled high; set wins over simultaneous clear.
REQ-021 BYPASS=1: a read whose rregnum equals an honoured same-cycle wregnum returns the winning wdata (REQ-019) combinationally; carry_rdata forwards carry_wdata when carry_we honoured.
REQ-022 BYPASS=0: reads return pre-edge contents; new value visible the cycle after the write.
REQ-023 Read/write index widths fixed at 6 bits independent of NREGS; no bits truncated before range check.

Reset
REQ-024 rst low asynchronously forces FSM=INIT, cnt=0, carry=0, wr_conflict=0, init_busy=1; all rdata read 0.
REQ-025 Register contents are not cleared asynchronously; clearing occurs only through the INIT sequence after rst rises.
REQ-026 rst asserted mid-INIT or mid-RUN restarts INIT from cnt=0 on release; in-flight writes that cycle are lost.

Verification
REQ-027 Release rst, NREGS=64 -> init_busy high exactly 64 cycles, writes during INIT ignored, all registers read 0 afterwards.
REQ-028 RUN, BYPASS=1, rega_we/regd_we both to index 5, wdata 16'h1111/16'h2222, rega_rregnum=5 -> rdata 16'h2222 same cycle, register[5]=16'h2222 next cycle, wr_conflict=1.
REQ-029 state=`STATE_HALTED, regb_we to 7 with 16'hAAAA and dbg_reg_we to 7 with 16'h5555 -> register[7]=16'h5555, no conflict flagged.
REQ-030 NREGS=16, write index 20 with 16'hFFFF -> no register changes; read index 20 returns 0.
REQ-031 BYPASS=0, write 16'h00C3 to index 3 while reading 3 -> old value this cycle, 16'h00C3 next cycle; carry_we=1, carry_wdata=1 -> carry_rdata=1 next cycle.
REQ-032 Pulse rst low mid-RUN -> carry and wr_conflict 0 immediately, full INIT sequence repeats.
